// File: rtl/uart_tx_buffered_if.sv
// Host-side byte handshake and serial-line status for uart_tx_buffered.
// master = byte producer, slave = transmitter.
interface uart_tx_buffered_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1/8N2 UART transmitter with a one-byte holding register so that
// consecutive frames leave the shift register with no idle gap.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic               i_Clock,
  input logic               i_Reset,
  uart_tx_buffered_if.slave tx
);
  localparam logic [16:0] BIT_LAST  = 17'(CLKS_PER_BIT - 1);
  localparam logic [16:0] STOP_LAST = 17'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [16:0] STOP_PRE  = 17'(STOP_BITS * CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } state_t;

  state_t      r_state,     w_state_nxt;
  logic [16:0] r_clk_cnt,   w_clk_cnt_nxt;
  logic [2:0]  r_bit_idx,   w_bit_idx_nxt;
  logic [7:0]  r_shift,     w_shift_nxt;
  logic [7:0]  r_hold,      w_hold_nxt;
  logic        r_hold_full, w_hold_full_nxt;
  logic        r_serial,    w_serial_nxt;
  logic        r_active,    w_active_nxt;
  logic        r_done,      w_done_nxt;
  logic        w_load;
  logic        w_accept;

  assign w_accept = tx.i_TX_DV & ~r_hold_full;

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_serial_nxt    = r_serial;
    w_active_nxt    = r_active;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;

    case (r_state)
      IDLE: begin
        w_serial_nxt = 1'b1;
        w_active_nxt = 1'b0;
        if (r_hold_full) begin
          w_load        = 1'b1;
          w_state_nxt   = TX_START_BIT;
          w_serial_nxt  = 1'b0;
          w_active_nxt  = 1'b1;
          w_clk_cnt_nxt = '0;
        end
      end
      TX_START_BIT: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_state_nxt   = TX_DATA_BITS;
          w_serial_nxt  = r_shift[0];
          w_bit_idx_nxt = '0;
          w_clk_cnt_nxt = '0;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 17'd1;
        end
      end
      TX_DATA_BITS: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt  = TX_STOP_BIT;
            w_serial_nxt = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = r_shift >> 1;
            w_serial_nxt  = r_shift[1];
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 17'd1;
        end
      end
      TX_STOP_BIT: begin
        // Done is registered one clock early so it lines up with the last stop clock.
        w_done_nxt = (r_clk_cnt == STOP_PRE);
        if (r_clk_cnt == STOP_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_state_nxt  = TX_START_BIT;
            w_serial_nxt = 1'b0;
          end else begin
            w_state_nxt  = IDLE;
            w_active_nxt = 1'b0;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 17'd1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_serial_nxt = 1'b1;
        w_active_nxt = 1'b0;
      end
    endcase

    // Transfer and accept are exclusive: transfer needs a full holder, accept an empty one.
    if (w_load) begin
      w_shift_nxt     = r_hold;
      w_hold_full_nxt = 1'b0;
    end
    if (w_accept) begin
      w_hold_nxt      = tx.i_TX_Byte;
      w_hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_serial    <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_serial    <= w_serial_nxt;
      r_active    <= w_active_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign tx.o_TX_Ready  = ~r_hold_full;
  assign tx.o_TX_Active = r_active;
  assign tx.o_TX_Serial = r_serial;
  assign tx.o_TX_Done   = r_done;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: bytes are queued as they are handed to the transmitter and
// popped by a behavioural UART receiver sampling mid-bit on the serial line.
module tb_uart_tx_buffered;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 217;
  localparam int unsigned FRAME_A = 10 * NA;
  localparam int unsigned FRAME_B = 11 * NB;
  localparam int unsigned LB_BYTES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buffered_if ifa ();
  uart_tx_buffered_if ifb ();

  uart_tx_buffered #(.CLKS_PER_BIT(NA), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .tx(ifa)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(NB), .STOP_BITS(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .tx(ifb)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  sb_a[$], sb_b[$];
  int unsigned done_qa[$], done_qb[$], run_qa[$], run_qb[$];
  int unsigned run_a = 0, run_b = 0, rx_cnt_a = 0, rx_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ser(input bit b);
    return b ? ifb.o_TX_Serial : ifa.o_TX_Serial;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Done timestamps and lengths of each continuous Active run.
  initial forever begin
    @(negedge clk);
    if (ifa.o_TX_Done === 1'b1) done_qa.push_back(cyc);
    if (ifb.o_TX_Done === 1'b1) done_qb.push_back(cyc);
    if (ifa.o_TX_Active === 1'b1) run_a++;
    else if (run_a != 0) begin run_qa.push_back(run_a); run_a = 0; end
    if (ifb.o_TX_Active === 1'b1) run_b++;
    else if (run_b != 0) begin run_qb.push_back(run_b); run_b = 0; end
  end

  task automatic rx_mon(input bit b, input int unsigned n);
    logic [7:0] d;
    logic [7:0] e;
    bit live;
    forever begin
      @(negedge clk);
      if (!rst && ser(b) === 1'b0) begin
        live = 1'b1;
        d = '0;
        for (int unsigned i = 1; live && i <= 9 * n + n / 2; i++) begin
          @(negedge clk);
          if (rst) live = 1'b0;
          else if (i >= n + n / 2 && (i - n / 2) % n == 0) begin
            if (i < 9 * n) d[(i - n / 2) / n - 1] = ser(b);
            else begin
              check(b ? "rx_stop_b" : "rx_stop_a", 32'(ser(b)), 1);
              check(b ? "rx_sb_nonempty_b" : "rx_sb_nonempty_a",
                    32'((b ? sb_b.size() : sb_a.size()) != 0), 1);
              if (b && sb_b.size() != 0) begin
                e = sb_b.pop_front();
                check("rx_byte_b", 32'(d), 32'(e));
              end else if (!b && sb_a.size() != 0) begin
                e = sb_a.pop_front();
                check("rx_byte_a", 32'(d), 32'(e));
              end
              if (b) rx_cnt_b++; else rx_cnt_a++;
            end
          end
        end
      end
    end
  endtask

  initial begin
    fork
      rx_mon(1'b0, NA);
      rx_mon(1'b1, NB);
    join_none
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input bit b, input logic [7:0] d);
    int unsigned n = 0;
    @(negedge clk);
    while (!(b ? ifb.o_TX_Ready : ifa.o_TX_Ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(b ? "ready_wait_b" : "ready_wait_a", 32'(b ? ifb.o_TX_Ready : ifa.o_TX_Ready), 1);
    if (b) begin
      ifb.i_TX_DV = 1'b1; ifb.i_TX_Byte = d; sb_b.push_back(d);
    end else begin
      ifa.i_TX_DV = 1'b1; ifa.i_TX_Byte = d; sb_a.push_back(d);
    end
    @(negedge clk);
    ifa.i_TX_DV = 1'b0;
    ifb.i_TX_DV = 1'b0;
  endtask

  task automatic wait_idle(input bit b, input int unsigned bound);
    int unsigned n = 0;
    while ((b ? ifb.o_TX_Active : ifa.o_TX_Active) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(b ? "idle_b" : "idle_a", 32'(b ? ifb.o_TX_Active : ifa.o_TX_Active), 0);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    done_qa.delete(); done_qb.delete(); run_qa.delete(); run_qb.delete();
  endtask

  initial begin
    logic [9:0]  frame;
    int unsigned rx0;
    logic [7:0]  rb;

    // Reset held two clocks with DV asserted: nothing may be accepted.
    ifa.i_TX_DV = 1'b1; ifa.i_TX_Byte = 8'hAA;
    ifb.i_TX_DV = 1'b1; ifb.i_TX_Byte = 8'h55;
    repeat (2) begin
      @(negedge clk);
      check("rst_serial", 32'(ifa.o_TX_Serial), 1);
      check("rst_ready",  32'(ifa.o_TX_Ready), 1);
      check("rst_active", 32'(ifa.o_TX_Active), 0);
      check("rst_done",   32'(ifa.o_TX_Done), 0);
      check("rst_serial_b", 32'(ifb.o_TX_Serial), 1);
    end
    rst = 1'b0;
    ifa.i_TX_DV = 1'b0;
    ifb.i_TX_DV = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_serial", 32'(ifa.o_TX_Serial), 1);
    check("post_rst_active", 32'(ifa.o_TX_Active), 0);
    check("post_rst_ready",  32'(ifa.o_TX_Ready), 1);

    // Single byte: exact line shape, Done on the 40th clock of the frame.
    clear_logs();
    frame = {1'b1, 8'hA5, 1'b0};
    send(1'b0, 8'hA5);
    check("a5_pre_serial", 32'(ifa.o_TX_Serial), 1);
    check("a5_pre_ready",  32'(ifa.o_TX_Ready), 0);
    for (int unsigned i = 0; i < FRAME_A; i++) begin
      @(negedge clk);
      check("a5_serial", 32'(ifa.o_TX_Serial), 32'(frame[i / NA]));
      check("a5_active", 32'(ifa.o_TX_Active), 1);
      check("a5_done",   32'(ifa.o_TX_Done), 32'(i == FRAME_A - 1));
    end
    @(negedge clk);
    check("a5_end_active", 32'(ifa.o_TX_Active), 0);
    check("a5_end_serial", 32'(ifa.o_TX_Serial), 1);
    check("a5_end_done",   32'(ifa.o_TX_Done), 0);
    @(negedge clk);
    check("a5_done_count", done_qa.size(), 1);
    check("a5_run_count",  run_qa.size(), 1);
    if (run_qa.size() != 0) check("a5_active_len", run_qa[0], FRAME_A);

    // Back-to-back: 0x00 then 0xFF as soon as ready rises.
    clear_logs();
    rx0 = rx_cnt_a;
    send(1'b0, 8'h00);
    send(1'b0, 8'hFF);
    wait_idle(1'b0, 200);
    @(negedge clk);
    check("b2b_rx_count", rx_cnt_a - rx0, 2);
    check("b2b_run_count", run_qa.size(), 1);
    if (run_qa.size() != 0) check("b2b_active_len", run_qa[0], 2 * FRAME_A);
    check("b2b_done_count", done_qa.size(), 2);
    if (done_qa.size() == 2) check("b2b_done_gap", done_qa[1] - done_qa[0], FRAME_A);

    // Overrun: 0x33 offered while the holding register is full must be dropped.
    clear_logs();
    rx0 = rx_cnt_a;
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    check("ovr_ready", 32'(ifa.o_TX_Ready), 0);
    ifa.i_TX_DV = 1'b1;
    ifa.i_TX_Byte = 8'h33;
    @(negedge clk);
    ifa.i_TX_DV = 1'b0;
    wait_idle(1'b0, 300);
    @(negedge clk);
    check("ovr_rx_count", rx_cnt_a - rx0, 2);
    check("ovr_sb_left", sb_a.size(), 0);
    check("ovr_done_count", done_qa.size(), 2);

    // Reset during data bit 3 of 0x0F aborts the frame silently.
    clear_logs();
    rx0 = rx_cnt_a;
    send(1'b0, 8'h0F);
    repeat (18) @(negedge clk);
    check("mid_active_before", 32'(ifa.o_TX_Active), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_a.delete();
    check("mid_serial",  32'(ifa.o_TX_Serial), 1);
    check("mid_active",  32'(ifa.o_TX_Active), 0);
    check("mid_done",    32'(ifa.o_TX_Done), 0);
    check("mid_ready",   32'(ifa.o_TX_Ready), 1);
    repeat (60) @(negedge clk);
    check("mid_idle_serial", 32'(ifa.o_TX_Serial), 1);
    check("mid_no_done", done_qa.size(), 0);
    check("mid_no_rx", rx_cnt_a - rx0, 0);

    // Loopback at 217 clocks/bit, two stop bits, random bytes back-to-back.
    clear_logs();
    rx0 = rx_cnt_b;
    for (int unsigned k = 0; k < LB_BYTES; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(1'b1, rb);
    end
    wait_idle(1'b1, 3 * FRAME_B);
    @(negedge clk);
    check("lb_rx_count", rx_cnt_b - rx0, LB_BYTES);
    check("lb_sb_left", sb_b.size(), 0);
    check("lb_done_count", done_qb.size(), LB_BYTES);
    for (int unsigned i = 1; i < done_qb.size(); i++)
      check("lb_frame_len", done_qb[i] - done_qb[i - 1], FRAME_B);
    check("lb_run_count", run_qb.size(), 1);
    if (run_qb.size() != 0) check("lb_active_len", run_qb[0], LB_BYTES * FRAME_B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
